// File: rtl/distortion_scan_ctrl.sv
// Distortion-mode scan sequencer: steps the amplifier switch code, settles, discards stale
// FFT frames and captures THD numer/denom per mode. Optional build macro: DISTSCAN_AVG_EN.
module distortion_scan_ctrl #(
  parameter int          NUM_MODES      = 5,
  parameter int          DISCARD_FRAMES = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd3_200_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [NUM_MODES-1:0] i_mode_mask,
  input  logic [15:0]          i_settle_cycles,
  input  logic                 i_result_valid,
  input  logic [11:0]          i_numer,
  input  logic [11:0]          i_denom,
  output logic [3:0]           o_switch,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NUM_MODES-1:0] o_valid_mask,
  output logic [NUM_MODES-1:0] o_err_mask,
  input  logic [2:0]           i_rd_idx,
  output logic [11:0]          o_rd_numer,
  output logic [11:0]          o_rd_denom,
  output logic [2:0]           o_dbg_state
);

  localparam int IW = $clog2(NUM_MODES + 1);
  localparam int DW = (DISCARD_FRAMES > 0) ? $clog2(DISCARD_FRAMES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_DISCARD, S_CAPTURE, S_FINISH
  } state_t;

  localparam state_t S_WAIT0 = (DISCARD_FRAMES == 0) ? S_CAPTURE : S_DISCARD;

  // i_start, i_abort and i_result_valid are single-cycle pulses with no back-pressure:
  // a pulse is consumed on the edge that samples it or it is lost.
  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [NUM_MODES-1:0]  r_mask;
  logic [15:0]           r_settle;
  logic [15:0]           r_cnt;
  logic [23:0]           r_tmo;
  logic [DW-1:0]         r_disc;
  logic [3:0]            r_switch;
  logic                  r_busy;
  logic                  r_done;
  logic [NUM_MODES-1:0]  r_valid;
  logic [NUM_MODES-1:0]  r_err;
  logic [11:0]           r_bank_n [NUM_MODES];
  logic [11:0]           r_bank_d [NUM_MODES];
  logic [11:0]           r_rd_numer;
  logic [11:0]           r_rd_denom;
  logic [11:0]           w_rd_n;
  logic [11:0]           w_rd_d;
  logic                  w_tmo_hit;

`ifdef DISTSCAN_AVG_EN
  logic        r_half;
  logic [11:0] r_a_n;
  logic [11:0] r_a_d;
  logic [12:0] w_sum_n;
  logic [12:0] w_sum_d;
  assign w_sum_n = {1'b0, r_a_n} + {1'b0, i_numer};
  assign w_sum_d = {1'b0, r_a_d} + {1'b0, i_denom};
`endif

  assign w_tmo_hit = (r_tmo == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    w_rd_n = '0;
    w_rd_d = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (i_rd_idx == 3'(i)) begin
        w_rd_n = r_bank_n[i];
        w_rd_d = r_bank_d[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_mask     <= '0;
      r_settle   <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_disc     <= '0;
      r_switch   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= '0;
      r_err      <= '0;
      r_rd_numer <= '0;
      r_rd_denom <= '0;
      for (int i = 0; i < NUM_MODES; i++) begin
        r_bank_n[i] <= '0;
        r_bank_d[i] <= '0;
      end
`ifdef DISTSCAN_AVG_EN
      r_half <= 1'b0;
      r_a_n  <= '0;
      r_a_d  <= '0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_rd_numer <= w_rd_n;
      r_rd_denom <= w_rd_d;
      if (i_abort && r_state != S_IDLE) begin
        // Abort keeps completed bank entries and mask bits as they stand.
        r_state  <= S_IDLE;
        r_switch <= '0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              r_mask   <= i_mode_mask;
              r_settle <= i_settle_cycles;
              r_valid  <= '0;
              r_err    <= '0;
              r_idx    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_SELECT;
            end
          end
          S_SELECT: begin
            if (r_idx == IW'(NUM_MODES)) begin
              r_switch <= '0;
              r_state  <= S_FINISH;
            end else if (!r_mask[r_idx]) begin
              r_idx <= r_idx + IW'(1);
            end else begin
              r_switch <= 4'(r_idx) + 4'd1;
              r_cnt    <= r_settle;
              r_tmo    <= '0;
              r_disc   <= '0;
`ifdef DISTSCAN_AVG_EN
              r_half   <= 1'b0;
`endif
              r_state  <= (r_settle == 16'd0) ? S_WAIT0 : S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (r_cnt == 16'd1) r_state <= S_WAIT0;
            else                r_cnt   <= r_cnt - 16'd1;
          end
          S_DISCARD, S_CAPTURE: begin
            if (i_result_valid) begin
              r_tmo <= '0;
              if (r_state == S_DISCARD) begin
                if (int'(r_disc) == DISCARD_FRAMES - 1) r_state <= S_CAPTURE;
                else                                    r_disc  <= r_disc + DW'(1);
              end else begin
`ifdef DISTSCAN_AVG_EN
                if (!r_half) begin
                  r_half <= 1'b1;
                  r_a_n  <= i_numer;
                  r_a_d  <= i_denom;
                end else begin
                  r_bank_n[r_idx] <= w_sum_n[12:1];
                  r_bank_d[r_idx] <= w_sum_d[12:1];
                  r_valid[r_idx]  <= 1'b1;
                  r_idx           <= r_idx + IW'(1);
                  r_state         <= S_SELECT;
                end
`else
                r_bank_n[r_idx] <= i_numer;
                r_bank_d[r_idx] <= i_denom;
                r_valid[r_idx]  <= 1'b1;
                r_idx           <= r_idx + IW'(1);
                r_state         <= S_SELECT;
`endif
              end
            end else if (w_tmo_hit) begin
              r_err[r_idx] <= 1'b1;
              r_idx        <= r_idx + IW'(1);
              r_state      <= S_SELECT;
            end else begin
              r_tmo <= r_tmo + 24'd1;
            end
          end
          S_FINISH: begin
            r_switch <= '0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_switch     = r_switch;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_valid_mask = r_valid;
  assign o_err_mask   = r_err;
  assign o_rd_numer   = r_rd_numer;
  assign o_rd_denom   = r_rd_denom;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_distortion_scan_ctrl.sv
// Bench for distortion_scan_ctrl: event-time scan model over a pulse schedule, a read-port
// vector table, and directed sequences for timeout, abort and reset corners.
module tb_distortion_scan_ctrl;

  localparam int          NM   = 5;
  localparam int          DISC = 2;
  localparam int          T    = 60;
  localparam logic [23:0] TMO  = 24'd60;
  localparam int          WIN  = 1400;
`ifdef DISTSCAN_AVG_EN
  localparam int NSAMP = 2;
`else
  localparam int NSAMP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort, rv;
  logic [4:0]  mask;
  logic [15:0] settle;
  logic [11:0] numer, denom;
  logic [3:0]  sw;
  logic        busy, done;
  logic [4:0]  vmask, emask;
  logic [2:0]  rd_idx;
  logic [11:0] rd_n, rd_d;
  logic [2:0]  dbg_state;

  distortion_scan_ctrl #(.NUM_MODES(NM), .DISCARD_FRAMES(DISC), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_mode_mask(mask), .i_settle_cycles(settle), .i_result_valid(rv),
    .i_numer(numer), .i_denom(denom), .o_switch(sw), .o_busy(busy), .o_done(done),
    .o_valid_mask(vmask), .o_err_mask(emask), .i_rd_idx(rd_idx),
    .o_rd_numer(rd_n), .o_rd_denom(rd_d), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic        rv_s [WIN];
  logic [11:0] nv_s [WIN];
  logic [11:0] dv_s [WIN];
  logic [11:0] bank_n [NM];
  logic [11:0] bank_d [NM];
  logic [23:0] exp_q [$];

  int          m_sel [NM];
  int          m_end [NM];
  logic        m_ok  [NM];
  logic [11:0] m_n   [NM];
  logic [11:0] m_d   [NM];
  int          m_fin, m_done_full, m_ab;
  logic [4:0]  m_valid, m_err;
  int          obs_done;

  typedef struct {
    logic [2:0]  idx;
    logic [11:0] n;
    logic [11:0] d;
  } rd_vec_t;
  rd_vec_t rd_tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rv_at(input int p);
    return (p >= 0 && p < WIN) ? rv_s[p] : 1'b0;
  endfunction
  function automatic logic [11:0] nv_at(input int p);
    return (p >= 0 && p < WIN) ? nv_s[p] : 12'd0;
  endfunction
  function automatic logic [11:0] dv_at(input int p);
    return (p >= 0 && p < WIN) ? dv_s[p] : 12'd0;
  endfunction

  // Timeline model in edge numbers: edge 0 samples start, each mode index costs one
  // SELECT edge, enabled modes then settle and wait for pulses with a rolling deadline.
  task automatic model_scan(input logic [4:0] mk, input int st, input int ab);
    int t, p, dl, got, sum_n, sum_d;
    logic ok;
    t = 0;
    for (int i = 0; i < NM; i++) begin
      m_sel[i] = -1;
      m_end[i] = -1;
      m_ok[i]  = 1'b0;
      t++;
      if (mk[i]) begin
        m_sel[i] = t;
        p = t + st + 1;
        dl = p + T - 1;
        got = 0; sum_n = 0; sum_d = 0; ok = 1'b0;
        while (p <= dl) begin
          if (rv_at(p)) begin
            got++;
            if (got > DISC) begin
              sum_n += int'(nv_at(p));
              sum_d += int'(dv_at(p));
            end
            dl = p + T;
            if (got == DISC + NSAMP) begin
              ok = 1'b1;
              break;
            end
          end
          p++;
        end
        m_ok[i] = ok;
        if (ok) begin
          m_end[i] = p;
          m_n[i] = 12'(sum_n / NSAMP);
          m_d[i] = 12'(sum_d / NSAMP);
          t = p;
        end else begin
          m_end[i] = dl;
          t = dl;
        end
      end
    end
    m_fin = t + 1;
    m_done_full = t + 2;
    m_ab = (ab >= 0 && ab <= m_done_full) ? ab : -1;
    m_valid = '0;
    m_err = '0;
    for (int i = 0; i < NM; i++) begin
      if (m_end[i] >= 0 && (m_ab < 0 || m_end[i] < m_ab)) begin
        if (m_ok[i]) begin
          m_valid[i] = 1'b1;
          bank_n[i] = m_n[i];
          bank_d[i] = m_d[i];
        end else begin
          m_err[i] = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_sw(input int e);
    logic [3:0] s;
    s = 4'd0;
    if (m_ab >= 0 && e >= m_ab) return 4'd0;
    for (int i = 0; i < NM; i++)
      if (m_sel[i] >= 0 && e >= m_sel[i]) s = 4'(i + 1);
    if (e >= m_fin) s = 4'd0;
    return s;
  endfunction

  function automatic logic exp_busy(input int e);
    if (m_ab >= 0 && e >= m_ab) return 1'b0;
    return e < m_done_full;
  endfunction

  function automatic logic exp_done(input int e);
    return (m_ab < 0) && (e == m_done_full);
  endfunction

  task automatic check_bank();
    logic [23:0] ev;
    for (int i = 0; i < 8; i++) begin
      if (i < NM) exp_q.push_back({bank_n[i], bank_d[i]});
      else        exp_q.push_back(24'd0);
    end
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      chk($sformatf("rd_numer[%0d]", i), 32'(rd_n), 32'(ev[23:12]));
      chk($sformatf("rd_denom[%0d]", i), 32'(rd_d), 32'(ev[11:0]));
    end
    rd_idx = 3'd0;
  endtask

  task automatic run_scan(input logic [4:0] mk, input int st, input int ab, input logic want_xs);
    int last, xs;
    model_scan(mk, st, ab);
    xs = -1;
    if (want_xs && m_done_full > 2) xs = $urandom_range(1, m_done_full - 1);
    if (m_ab >= 0 && xs >= m_ab) xs = -1;
    last = (m_ab >= 0) ? m_ab + 8 : m_done_full + 3;
    obs_done = -1;
    for (int e = 0; e <= last; e++) begin
      start = (e == 0) || (e == xs);
      abort = (e == ab);
      if (e == 0) begin
        mask = mk;
        settle = 16'(st);
      end else begin
        mask = 5'($urandom);
        settle = 16'($urandom_range(0, 40));
      end
      rv = rv_at(e);
      numer = nv_at(e);
      denom = dv_at(e);
      @(posedge clk); #1;
      if (done && obs_done < 0) obs_done = e;
      chk($sformatf("switch@%0d", e), 32'(sw), 32'(exp_sw(e)));
      chk($sformatf("busy@%0d", e), 32'(busy), 32'(exp_busy(e)));
      chk($sformatf("done@%0d", e), 32'(done), 32'(exp_done(e)));
    end
    start = 1'b0; abort = 1'b0; rv = 1'b0;
    chk("valid_mask", 32'(vmask), 32'(m_valid));
    chk("err_mask", 32'(emask), 32'(m_err));
    check_bank();
  endtask

  task automatic clear_sched();
    for (int p = 0; p < WIN; p++) begin
      rv_s[p] = 1'b0;
      nv_s[p] = 12'($urandom);
      dv_s[p] = 12'($urandom);
    end
  endtask

  task automatic fill_random();
    int p;
    clear_sched();
    p = $urandom_range(0, 10);
    while (p < WIN) begin
      rv_s[p] = 1'b1;
      p += ($urandom_range(0, 11) == 0) ? 70 : $urandom_range(1, 25);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_switch"}, 32'(sw), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_valid"}, 32'(vmask), 32'd0);
    chk({tag, "_err"}, 32'(emask), 32'd0);
    chk({tag, "_rd_numer"}, 32'(rd_n), 32'd0);
    chk({tag, "_rd_denom"}, 32'(rd_d), 32'd0);
  endtask

  initial begin
    rd_tab[0] = '{3'd0, 12'd100, 12'd1000};
    rd_tab[1] = '{3'd1, 12'd0,   12'd0};
    rd_tab[2] = '{3'd2, 12'd200, 12'd2000};
    rd_tab[3] = '{3'd3, 12'd0,   12'd0};
    rd_tab[4] = '{3'd4, 12'd0,   12'd0};
    rd_tab[5] = '{3'd5, 12'd0,   12'd0};
    rd_tab[6] = '{3'd6, 12'd0,   12'd0};
    rd_tab[7] = '{3'd7, 12'd0,   12'd0};
    for (int i = 0; i < NM; i++) begin
      bank_n[i] = '0;
      bank_d[i] = '0;
    end

    // clock/reset
    rst = 1'b1; start = 1'b0; abort = 1'b0; rv = 1'b0;
    mask = '0; settle = '0; numer = '0; denom = '0; rd_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // two enabled modes, pulses every 20 edges
    clear_sched();
    for (int p = 20; p < WIN; p += 20) begin
      rv_s[p] = 1'b1;
      nv_s[p] = (p <= 60) ? 12'd100 : 12'd200;
      dv_s[p] = (p <= 60) ? 12'd1000 : 12'd2000;
    end
    run_scan(5'b00101, 10, -1, 1'b0);
`ifndef DISTSCAN_AVG_EN
    chk("scan1_done_edge", 32'(obs_done), 32'd124);
    chk("scan1_valid", 32'(vmask), 32'b00101);
    for (int k = 0; k < 8; k++) begin
      rd_idx = rd_tab[k].idx;
      @(posedge clk); #1;
      chk($sformatf("tab_numer[%0d]", k), 32'(rd_n), 32'(rd_tab[k].n));
      chk($sformatf("tab_denom[%0d]", k), 32'(rd_d), 32'(rd_tab[k].d));
    end
    rd_idx = 3'd0;
`endif

    // empty mask
    fill_random();
    run_scan(5'b00000, 7, -1, 1'b0);
    chk("empty_done_edge", 32'(obs_done), 32'd7);

    // mode 1 never sees a pulse
    clear_sched();
    rv_s[80] = 1'b1; rv_s[90] = 1'b1; rv_s[100] = 1'b1;
    run_scan(5'b00110, 5, -1, 1'b0);
`ifndef DISTSCAN_AVG_EN
    chk("tmo_done_edge", 32'(obs_done), 32'd104);
    chk("tmo_err", 32'(emask), 32'b00010);
    chk("tmo_valid", 32'(vmask), 32'b00100);
`endif

    // abort during mode 2 settle
    clear_sched();
    for (int p = 5; p < WIN; p += 5) rv_s[p] = 1'b1;
    run_scan(5'b00111, 30, 100, 1'b0);
    chk("abort_no_done", 32'(obs_done), 32'hffff_ffff);
`ifndef DISTSCAN_AVG_EN
    chk("abort_valid", 32'(vmask), 32'b00011);
`endif

    // abort and start in the same idle cycle
    start = 1'b1; abort = 1'b1; mask = 5'b11111; settle = 16'd0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("abort_start_busy2", 32'(busy), 32'd0);
    chk("abort_start_valid", 32'(vmask), 32'(m_valid));

    // random scans, some with a mid-scan abort and a stray start
    for (int s = 0; s < 10; s++) begin
      fill_random();
      run_scan(5'($urandom), $urandom_range(0, 20),
               (s % 4 == 3) ? int'($urandom_range(5, 300)) : -1, 1'b1);
    end

    // reset while waiting in CAPTURE
    clear_sched();
    rv_s[2] = 1'b1; rv_s[3] = 1'b1;
    rd_idx = 3'd0;
    for (int e = 0; e <= 3; e++) begin
      start = (e == 0);
      mask = 5'b00001;
      settle = 16'd0;
      rv = rv_s[e];
      @(posedge clk); #1;
    end
    start = 1'b0; rv = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("midrst");
    for (int i = 0; i < NM; i++) begin
      bank_n[i] = '0;
      bank_d[i] = '0;
    end
    rd_idx = 3'd7;
    @(posedge clk); #1;
    chk("rd7_numer", 32'(rd_n), 32'd0);
    chk("rd7_denom", 32'(rd_d), 32'd0);
    check_bank();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
